// File: rtl/led_status_ctrl.sv
// Shares the single status LED between a heartbeat source and NUM_REQ round-robin
// requesters; a grantee's N-pulse blink code is played out, followed by a dark gap and an ack.
module led_status_ctrl #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CODE_WIDTH = 4,
    parameter string       IS_DEBUG   = "false",
    parameter int unsigned ON_TICKS   = 2,
    parameter int unsigned OFF_TICKS  = 2,
    parameter int unsigned GAP_TICKS  = 8
) (
    input  logic                             i_clk,
    input  logic                             i_a_rst,
    input  logic                             i_heart_beat,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*CODE_WIDTH-1:0]    i_code,
    output logic [NUM_REQ-1:0]               o_ack,
    output logic                             o_busy,
    output logic [$clog2(NUM_REQ)-1:0]       o_owner,
    output logic                             o_led
);

    localparam int unsigned RATE        = (IS_DEBUG == "true") ? 120 : 120_000_000;
    localparam int unsigned TICK_CYCLES = RATE / 8;
    localparam int unsigned PRW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TW          = $clog2(GAP_TICKS + 1);
    localparam int unsigned PW          = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t                state, state_d;
    logic [PW-1:0]         ptr, ptr_d;
    logic [PW-1:0]         owner, owner_d;
    logic [CODE_WIDTH-1:0] pulse_cnt, pulse_d;
    logic [PRW-1:0]        presc, presc_d;
    logic [TW-1:0]         tick_cnt, tick_d;
    logic [NUM_REQ-1:0]    ack_d;

    logic [NUM_REQ-1:0]    rot, scan;
    logic                  found;
    logic [PW:0]           sum;
    logic [PW-1:0]         win, ptr_adv;
    logic [CODE_WIDTH-1:0] code_sel;
    logic                  tick_end, phase_end;
    logic [TW-1:0]         last_tick;

    // Round-robin search: rotate requests so ptr sits at bit 0, take the first set bit.
    always_comb begin
        rot   = (i_req >> ptr) | (i_req << (NUM_REQ - int'(ptr)));
        scan  = rot;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && scan[0]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(i);
            end
            scan = scan >> 1;
        end
        if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
        end
        win      = sum[PW-1:0];
        ptr_adv  = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
        code_sel = CODE_WIDTH'(i_code >> (int'(win) * CODE_WIDTH));
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        pulse_d = pulse_cnt;
        presc_d = presc;
        tick_d  = tick_cnt;
        ack_d   = '0;

        tick_end = (presc == PRW'(TICK_CYCLES - 1));
        unique case (state)
            ON:      last_tick = TW'(ON_TICKS - 1);
            OFF:     last_tick = TW'(OFF_TICKS - 1);
            default: last_tick = TW'(GAP_TICKS - 1);
        endcase
        phase_end = tick_end && (tick_cnt == last_tick);

        if (state != IDLE) begin
            if (tick_end) begin
                presc_d = '0;
                tick_d  = tick_cnt + TW'(1);
            end else begin
                presc_d = presc + PRW'(1);
            end
        end

        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_d = win;
                    ptr_d   = ptr_adv;
                    if (code_sel == '0) begin
                        ack_d = NUM_REQ'(1) << win;
                    end else begin
                        state_d = ON;
                        pulse_d = code_sel;
                    end
                end
            end
            ON: begin
                if (phase_end) begin
                    pulse_d = pulse_cnt - CODE_WIDTH'(1);
                    state_d = (pulse_cnt > CODE_WIDTH'(1)) ? OFF : GAP;
                end
            end
            OFF: if (phase_end) state_d = ON;
            GAP: if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Each phase starts from a clean prescaler and tick count.
        if (state_d != state) begin
            presc_d = '0;
            tick_d  = '0;
        end

        // Register the ack so it lands exactly in the final GAP cycle.
        if (state_d == GAP && tick_d == TW'(GAP_TICKS - 1) && presc_d == PRW'(TICK_CYCLES - 1)) begin
            ack_d = NUM_REQ'(1) << owner_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            pulse_cnt <= '0;
            presc     <= '0;
            tick_cnt  <= '0;
            o_ack     <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            owner     <= owner_d;
            pulse_cnt <= pulse_d;
            presc     <= presc_d;
            tick_cnt  <= tick_d;
            o_ack     <= ack_d;
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_owner = owner;

    // Heartbeat passes straight through while idle.
    always_comb begin
        o_led = i_heart_beat;
        unique case (state)
            ON:      o_led = 1'b1;
            OFF:     o_led = 1'b0;
            GAP:     o_led = 1'b0;
            default: o_led = i_heart_beat;
        endcase
    end

endmodule
